// File: rtl/crossing_request.sv
// Pedestrian request front-end: synchronises and debounces the push-button, enforces a
// minimum car-green dwell before raising the request, and drives the WAIT lamp and press count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no open request; a debounced press opens one
// S_PENDING | request accepted, waiting for minimum car-green dwell
// S_ISSUED  | request level presented to controller (button high)
// S_SERVING | car-green ended, waiting for pedestrian green
// S_WALK    | pedestrian green active; new presses are ignored
module crossing_request #(
   parameter int DB_CYCLES = 16,
   parameter int MIN_GREEN = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       button_raw_i,
   input  logic       green_c_i,
   input  logic       green_p_i,
   output logic       button_o,
   output logic       wait_lamp_o,
   output logic [7:0] press_count_o
);

   localparam int DBW = $clog2(DB_CYCLES);
   localparam int GTW = $clog2(MIN_GREEN + 1);
   localparam logic [DBW-1:0] DBC_LAST = DBW'(DB_CYCLES - 1);
   localparam logic [GTW-1:0] GT_MAX   = GTW'(MIN_GREEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PENDING,
      S_ISSUED,
      S_SERVING,
      S_WALK
   } state_t;

   state_t         state_q, state_d;
   logic           s1_q, s1_d, s2_q, s2_d;
   logic           db_q, db_d, db_dly_q;
   logic [DBW-1:0] dbc_q, dbc_d;
   logic [GTW-1:0] gt_q, gt_d;
   logic [7:0]     cnt_q, cnt_d;
   logic           button_q, button_d;
   logic           wait_q, wait_d;
   logic           press;

   assign press = db_q & ~db_dly_q;

   always_comb begin
      s1_d  = button_raw_i;
      s2_d  = s1_q;
      db_d  = db_q;
      dbc_d = '0;
      // the level flips only on the DB_CYCLES-th consecutive disagreeing edge
      if (s2_q != db_q) begin
         if (dbc_q == DBC_LAST) begin
            db_d = s2_q;
         end else begin
            dbc_d = dbc_q + 1'b1;
         end
      end

      gt_d = '0;
      if (green_c_i) begin
         gt_d = (gt_q == GT_MAX) ? gt_q : gt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (press) begin
               state_d = S_PENDING;
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
         end
         S_PENDING: if (green_c_i && gt_q == GT_MAX) state_d = S_ISSUED;
         S_ISSUED:  if (!green_c_i) state_d = S_SERVING;
         S_SERVING: if (green_p_i) state_d = S_WALK;
         S_WALK:    if (!green_p_i) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      button_d = (state_d == S_ISSUED);
      wait_d   = (state_d == S_PENDING) || (state_d == S_ISSUED) || (state_d == S_SERVING);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         dbc_q    <= '0;
         gt_q     <= '0;
         cnt_q    <= 8'd0;
         button_q <= 1'b0;
         wait_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         db_q     <= db_d;
         db_dly_q <= db_q;
         dbc_q    <= dbc_d;
         gt_q     <= gt_d;
         cnt_q    <= cnt_d;
         button_q <= button_d;
         wait_q   <= wait_d;
      end
   end

   assign button_o      = button_q;
   assign wait_lamp_o   = wait_q;
   assign press_count_o = cnt_q;

endmodule

// File: tb/tb_crossing_request.sv
// Scoreboard bench for crossing_request: stimulus queues expected outputs keyed by edge
// number, a negedge monitor pops and compares them.
module tb_crossing_request;

   localparam int DB = 4;
   localparam int MG = 8;

   logic       clk = 1'b0;
   logic       rst, button_raw, green_c, green_p;
   logic       button, wait_lamp;
   logic [7:0] press_count;

   crossing_request #(.DB_CYCLES(DB), .MIN_GREEN(MG)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .button_raw_i  (button_raw),
      .green_c_i     (green_c),
      .green_p_i     (green_p),
      .button_o      (button),
      .wait_lamp_o   (wait_lamp),
      .press_count_o (press_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         when;
      logic [2:0] mask;
      logic       b;
      logic       w;
      logic [7:0] c;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // mask bits: [2] button, [1] wait_lamp, [0] press_count
   task automatic expect_at(input int when, input logic [2:0] mask, input logic b,
                            input logic w, input logic [7:0] c, input string tag);
      exp_t e;
      e.when = when;
      e.mask = mask;
      e.b    = b;
      e.w    = w;
      e.c    = c;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   exp_t m;
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].when <= cyc) begin
         m = sb.pop_front();
         n_vec++;
         if (m.when < cyc) begin
            n_err++;
            $display("FAIL %s: check missed (due after edge %0d, now %0d)", m.tag, m.when, cyc);
         end else if ((m.mask[2] && button !== m.b) || (m.mask[1] && wait_lamp !== m.w) ||
                      (m.mask[0] && press_count !== m.c)) begin
            n_err++;
            $display("FAIL %s: got button=%0b wait_lamp=%0b press_count=%0d, expected button=%0b wait_lamp=%0b press_count=%0d",
                     m.tag, button, wait_lamp, press_count, m.b, m.w, m.c);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   int base;
   int e0;

   initial begin
      rst = 1'b1; button_raw = 1'b1; green_c = 1'b1; green_p = 1'b0;
      expect_at(1, 3'b111, 1'b0, 1'b0, 8'd0, "reset_edge0");
      expect_at(2, 3'b111, 1'b0, 1'b0, 8'd0, "reset_edge1");
      expect_at(3, 3'b111, 1'b0, 1'b0, 8'd0, "reset_release");
      tick(2);
      rst = 1'b0; button_raw = 1'b0;
      tick(10);

      // bounces of 3 cycles never reach the 4-cycle debounce threshold
      repeat (5) begin
         button_raw = 1'b1; tick(3);
         button_raw = 1'b0; tick(1);
         expect_at(cyc, 3'b011, 1'b0, 1'b0, 8'd0, "bounce");
      end
      tick(8);
      expect_at(cyc, 3'b111, 1'b0, 1'b0, 8'd0, "bounce_settled");

      // clean press with long green
      base = cyc + 1;
      button_raw = 1'b1;
      expect_at(base + 5, 3'b111, 1'b0, 1'b0, 8'd0, "press_edge5");
      expect_at(base + 6, 3'b111, 1'b0, 1'b1, 8'd1, "press_edge6");
      expect_at(base + 7, 3'b111, 1'b1, 1'b1, 8'd1, "issue_edge7");
      tick(10);
      button_raw = 1'b0;

      // full crossing
      green_c = 1'b0; tick(1);
      expect_at(cyc, 3'b111, 1'b0, 1'b1, 8'd1, "button_fall");
      green_p = 1'b1; tick(1);
      expect_at(cyc, 3'b111, 1'b0, 1'b0, 8'd1, "wait_fall");
      tick(8);
      button_raw = 1'b1; tick(10);
      expect_at(cyc, 3'b111, 1'b0, 1'b0, 8'd1, "press_in_walk");
      button_raw = 1'b0; tick(8);
      green_p = 1'b0; tick(1);
      expect_at(cyc, 3'b111, 1'b0, 1'b0, 8'd1, "back_idle");
      base = cyc + 1;
      button_raw = 1'b1;
      expect_at(base + 6, 3'b111, 1'b0, 1'b1, 8'd2, "press_after_walk");
      tick(10);
      button_raw = 1'b0; tick(2);

      // minimum green from a PENDING request, green rising just after edge 0
      e0 = cyc;
      green_c = 1'b1;
      expect_at(e0 + 8, 3'b111, 1'b0, 1'b1, 8'd2, "min_green_edge8");
      expect_at(e0 + 9, 3'b111, 1'b1, 1'b1, 8'd2, "min_green_edge9");
      tick(10);
      green_c = 1'b0; tick(1);
      green_p = 1'b1; tick(1);
      green_p = 1'b0; tick(1);
      expect_at(cyc, 3'b111, 1'b0, 1'b0, 8'd2, "idle_again");

      // same with a one-cycle green dip sampled at edge 5
      base = cyc + 1;
      button_raw = 1'b1;
      expect_at(base + 6, 3'b111, 1'b0, 1'b1, 8'd3, "dip_press");
      tick(10);
      button_raw = 1'b0; tick(2);
      e0 = cyc;
      green_c = 1'b1; tick(4);
      green_c = 1'b0; tick(1);
      green_c = 1'b1;
      expect_at(e0 + 13, 3'b111, 1'b0, 1'b1, 8'd3, "dip_edge13");
      expect_at(e0 + 14, 3'b111, 1'b1, 1'b1, 8'd3, "dip_edge14");
      tick(10);

      // reset while ISSUED
      rst = 1'b1; tick(1);
      expect_at(cyc, 3'b111, 1'b0, 1'b0, 8'd0, "reset_mid_issued");
      rst = 1'b0;
      tick(10);

      // saturation of the press counter
      for (int i = 1; i <= 260; i++) begin
         button_raw = 1'b1; tick(8);
         if (i == 1 || i >= 254)
            expect_at(cyc, 3'b111, 1'b1, 1'b1, (i > 255) ? 8'd255 : 8'(i),
                      $sformatf("saturate_%0d", i));
         button_raw = 1'b0; green_c = 1'b0; tick(1);
         green_p = 1'b1; tick(1);
         green_p = 1'b0; tick(1);
         green_c = 1'b1; tick(10);
      end
      tick(2);
      expect_at(cyc, 3'b111, 1'b0, 1'b0, 8'd255, "final_idle");
      tick(3);

      while (sb.size() > 0) begin
         m = sb.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL %s: never checked (due after edge %0d)", m.tag, m.when);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
